// File: rtl/icb_apb_pkg.sv
// Shared types and widths for the ICB-to-APB bridge.
//   state_e      : bridge FSM states
//   ICB_AW/ICB_DW: ICB address / data widths
//   APB_DW       : APB data width
//   MASK_W       : ICB byte-mask width
//   in_window()  : address window membership test
package icb_apb_pkg;

    localparam int unsigned ICB_AW = 32;
    localparam int unsigned ICB_DW = 64;
    localparam int unsigned APB_DW = 32;
    localparam int unsigned MASK_W = 8;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StSetup  = 2'd1,
        StAccess = 2'd2,
        StResp   = 2'd3
    } state_e;

    // Subtract first so a window ending exactly at 2^32 does not overflow.
    function automatic logic in_window(input logic [ICB_AW-1:0] addr,
                                       input logic [ICB_AW-1:0] base,
                                       input logic [ICB_AW-1:0] size);
        logic [ICB_AW-1:0] offset;
        offset = addr - base;
        return (addr >= base) && (offset < size);
    endfunction

endpackage

// File: rtl/icb_modport.sv
// ICB slave endpoint that bridges one 64-bit ICB access at a time onto a 32-bit APB master.
// Single outstanding transaction: IDLE -> SETUP -> ACCESS -> RESP -> IDLE.
//
// Ports:
//   clk, rst_n                 : clock, synchronous active-low reset
//   icb_cmd_*                  : ICB command channel (valid/ready, addr, read, wdata, wmask)
//   icb_rsp_*                  : ICB response channel (valid/ready, rdata, err)
//   paddr..pprot               : APB master request outputs
//   prdata, pready, pslverr    : APB completer inputs
//
// Configuration macro ICB_RANGE_CHECK_EN: when defined, commands outside
// [BASE_ADDR, BASE_ADDR+ADDR_SIZE) get an immediate error response with no APB cycle.
module icb_modport
    import icb_apb_pkg::*;
#(
    parameter logic [ICB_AW-1:0] BASE_ADDR = 32'h1000_0000,
    parameter logic [ICB_AW-1:0] ADDR_SIZE = 32'h0000_1000
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              icb_cmd_valid,
    output logic              icb_cmd_ready,
    input  logic [ICB_AW-1:0] icb_cmd_addr,
    input  logic              icb_cmd_read,
    input  logic [ICB_DW-1:0] icb_cmd_wdata,
    input  logic [MASK_W-1:0] icb_cmd_wmask,

    output logic              icb_rsp_valid,
    input  logic              icb_rsp_ready,
    output logic [ICB_DW-1:0] icb_rsp_rdata,
    output logic              icb_rsp_err,

    output logic [ICB_AW-1:0] paddr,
    output logic              pwrite,
    output logic              psel,
    output logic              penable,
    output logic [APB_DW-1:0] pwdata,
    output logic [3:0]        pstrb,
    output logic [2:0]        pprot,
    input  logic [APB_DW-1:0] prdata,
    input  logic              pready,
    input  logic              pslverr
);

    state_e            state_q, state_d;
    logic              read_q, read_d;
    logic [ICB_AW-1:0] paddr_q, paddr_d;
    logic              pwrite_q, pwrite_d;
    logic              psel_q, psel_d;
    logic              penable_q, penable_d;
    logic [APB_DW-1:0] pwdata_q, pwdata_d;
    logic [3:0]        pstrb_q, pstrb_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [ICB_DW-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;

    logic cmd_fire;
    logic fwd_to_apb;
    logic upper_lane;

    assign icb_cmd_ready = (state_q == StIdle) & rst_n;
    assign cmd_fire      = icb_cmd_valid & icb_cmd_ready;
    assign upper_lane    = icb_cmd_addr[2];

`ifdef ICB_RANGE_CHECK_EN
    assign fwd_to_apb = in_window(icb_cmd_addr, BASE_ADDR, ADDR_SIZE);
`else
    assign fwd_to_apb = 1'b1;
`endif

    // Window parameters and the byte offset only matter with range checking enabled.
    logic unused_cfg;
    assign unused_cfg = ^{BASE_ADDR, ADDR_SIZE, icb_cmd_addr[1:0]};

    always_comb begin
        state_d     = state_q;
        read_d      = read_q;
        paddr_d     = paddr_q;
        pwrite_d    = pwrite_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwdata_d    = pwdata_q;
        pstrb_d     = pstrb_q;
        rsp_valid_d = rsp_valid_q;
        rdata_d     = rdata_q;
        err_d       = err_q;

        unique case (state_q)
            StIdle: begin
                if (cmd_fire) begin
                    if (fwd_to_apb) begin
                        read_d   = icb_cmd_read;
                        paddr_d  = {icb_cmd_addr[ICB_AW-1:2], 2'b00};
                        pwrite_d = ~icb_cmd_read;
                        // addr[2] picks which 32-bit half of the 64-bit beat goes out.
                        pwdata_d = upper_lane ? icb_cmd_wdata[63:32] : icb_cmd_wdata[31:0];
                        pstrb_d  = upper_lane ? icb_cmd_wmask[7:4] : icb_cmd_wmask[3:0];
                        psel_d   = 1'b1;
                        state_d  = StSetup;
                    end else begin
                        rsp_valid_d = 1'b1;
                        rdata_d     = '0;
                        err_d       = 1'b1;
                        state_d     = StResp;
                    end
                end
            end
            StSetup: begin
                penable_d = 1'b1;
                state_d   = StAccess;
            end
            StAccess: begin
                if (pready) begin
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rdata_d     = read_q ? {prdata, prdata} : '0;
                    err_d       = pslverr;
                    state_d     = StResp;
                end
            end
            StResp: begin
                if (icb_rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            read_q      <= 1'b0;
            paddr_q     <= '0;
            pwrite_q    <= 1'b0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwdata_q    <= '0;
            pstrb_q     <= '0;
            rsp_valid_q <= 1'b0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            read_q      <= read_d;
            paddr_q     <= paddr_d;
            pwrite_q    <= pwrite_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwdata_q    <= pwdata_d;
            pstrb_q     <= pstrb_d;
            rsp_valid_q <= rsp_valid_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
        end
    end

    assign paddr         = paddr_q;
    assign pwrite        = pwrite_q;
    assign psel          = psel_q;
    assign penable       = penable_q;
    assign pwdata        = pwdata_q;
    assign pstrb         = pstrb_q;
    assign pprot         = 3'b000;
    assign icb_rsp_valid = rsp_valid_q;
    assign icb_rsp_rdata = rdata_q;
    assign icb_rsp_err   = err_q;

endmodule

// File: tb/tb_icb_modport.sv
// Directed plus randomized bench for icb_modport: a transaction-level model computes the
// expected APB request and ICB response from each command and the completer's reply.
module tb_icb_modport;

    logic        clk;
    logic        rst_n;
    logic        icb_cmd_valid;
    logic        icb_cmd_ready;
    logic [31:0] icb_cmd_addr;
    logic        icb_cmd_read;
    logic [63:0] icb_cmd_wdata;
    logic [7:0]  icb_cmd_wmask;
    logic        icb_rsp_valid;
    logic        icb_rsp_ready;
    logic [63:0] icb_rsp_rdata;
    logic        icb_rsp_err;
    logic [31:0] paddr;
    logic        pwrite;
    logic        psel;
    logic        penable;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [2:0]  pprot;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    int n_checks = 0;
    int n_errors = 0;

    icb_modport dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .icb_cmd_valid (icb_cmd_valid),
        .icb_cmd_ready (icb_cmd_ready),
        .icb_cmd_addr  (icb_cmd_addr),
        .icb_cmd_read  (icb_cmd_read),
        .icb_cmd_wdata (icb_cmd_wdata),
        .icb_cmd_wmask (icb_cmd_wmask),
        .icb_rsp_valid (icb_rsp_valid),
        .icb_rsp_ready (icb_rsp_ready),
        .icb_rsp_rdata (icb_rsp_rdata),
        .icb_rsp_err   (icb_rsp_err),
        .paddr         (paddr),
        .pwrite        (pwrite),
        .psel          (psel),
        .penable       (penable),
        .pwdata        (pwdata),
        .pstrb         (pstrb),
        .pprot         (pprot),
        .prdata        (prdata),
        .pready        (pready),
        .pslverr       (pslverr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: window membership as seen by the bridge.
    function automatic logic model_forwards(input logic [31:0] a);
`ifdef ICB_RANGE_CHECK_EN
        return (a >= 32'h1000_0000) && (a < 32'h1000_1000);
`else
        return 1'b1;
`endif
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_txn(input logic [31:0] a, input logic rd, input logic [63:0] wd,
                          input logic [7:0] wm, input int unsigned waits,
                          input logic [31:0] prd, input logic slv, input int unsigned stall);
        logic [31:0] e_paddr;
        logic [31:0] e_pwdata;
        logic [3:0]  e_pstrb;
        logic [63:0] e_rdata;
        logic        e_err;
        int unsigned lane;

        lane     = a[2] ? 1 : 0;
        e_paddr  = (a / 4) * 4;
        e_pwdata = 32'(wd >> (32 * lane));
        e_pstrb  = 4'(wm >> (4 * lane));

        chk("cmd_ready_idle", {63'd0, icb_cmd_ready}, 64'd1);
        icb_cmd_valid = 1'b1;
        icb_cmd_addr  = a;
        icb_cmd_read  = rd;
        icb_cmd_wdata = wd;
        icb_cmd_wmask = wm;
        step();
        icb_cmd_valid = 1'b0;
        icb_cmd_addr  = $urandom;
        icb_cmd_wdata = {$urandom, $urandom};
        icb_cmd_wmask = 8'($urandom);

        if (!model_forwards(a)) begin
            e_rdata = 64'd0;
            e_err   = 1'b1;
            chk("oor_psel", {63'd0, psel}, 64'd0);
            chk("oor_rsp_valid", {63'd0, icb_rsp_valid}, 64'd1);
        end else begin
            e_rdata = rd ? {prd, prd} : 64'd0;
            e_err   = slv;
            chk("setup_psel", {63'd0, psel}, 64'd1);
            chk("setup_penable", {63'd0, penable}, 64'd0);
            chk("setup_paddr", {32'd0, paddr}, {32'd0, e_paddr});
            chk("setup_pwrite", {63'd0, pwrite}, {63'd0, ~rd});
            chk("setup_pwdata", {32'd0, pwdata}, {32'd0, e_pwdata});
            chk("setup_pstrb", {60'd0, pstrb}, {60'd0, e_pstrb});
            chk("setup_pprot", {61'd0, pprot}, 64'd0);
            chk("setup_cmd_ready", {63'd0, icb_cmd_ready}, 64'd0);
            step();
            chk("access_psel", {63'd0, psel}, 64'd1);
            chk("access_penable", {63'd0, penable}, 64'd1);
            chk("access_paddr", {32'd0, paddr}, {32'd0, e_paddr});
            chk("access_pwdata", {32'd0, pwdata}, {32'd0, e_pwdata});
            for (int i = 0; i < int'(waits); i++) begin
                step();
                chk("wait_psel", {63'd0, psel}, 64'd1);
                chk("wait_penable", {63'd0, penable}, 64'd1);
                chk("wait_rsp_valid", {63'd0, icb_rsp_valid}, 64'd0);
                chk("wait_pstrb", {60'd0, pstrb}, {60'd0, e_pstrb});
            end
            pready  = 1'b1;
            prdata  = prd;
            pslverr = slv;
            step();
            pready  = 1'b0;
            prdata  = $urandom;
            pslverr = 1'b0;
            chk("done_psel", {63'd0, psel}, 64'd0);
            chk("done_penable", {63'd0, penable}, 64'd0);
            chk("done_rsp_valid", {63'd0, icb_rsp_valid}, 64'd1);
        end
        chk("rsp_rdata", icb_rsp_rdata, e_rdata);
        chk("rsp_err", {63'd0, icb_rsp_err}, {63'd0, e_err});

        for (int i = 0; i < int'(stall); i++) begin
            step();
            chk("stall_rsp_valid", {63'd0, icb_rsp_valid}, 64'd1);
            chk("stall_rdata", icb_rsp_rdata, e_rdata);
            chk("stall_err", {63'd0, icb_rsp_err}, {63'd0, e_err});
            chk("stall_cmd_ready", {63'd0, icb_cmd_ready}, 64'd0);
        end
        icb_rsp_ready = 1'b1;
        step();
        icb_rsp_ready = 1'b0;
        chk("after_rsp_valid", {63'd0, icb_rsp_valid}, 64'd0);
        chk("after_cmd_ready", {63'd0, icb_cmd_ready}, 64'd1);
    endtask

    initial begin
        rst_n         = 1'b0;
        icb_cmd_valid = 1'b0;
        icb_cmd_addr  = '0;
        icb_cmd_read  = 1'b0;
        icb_cmd_wdata = '0;
        icb_cmd_wmask = '0;
        icb_rsp_ready = 1'b0;
        prdata        = '0;
        pready        = 1'b0;
        pslverr       = 1'b0;

        // Reset state
        step();
        step();
        chk("rst_psel", {63'd0, psel}, 64'd0);
        chk("rst_penable", {63'd0, penable}, 64'd0);
        chk("rst_rsp_valid", {63'd0, icb_rsp_valid}, 64'd0);
        chk("rst_paddr", {32'd0, paddr}, 64'd0);
        chk("rst_cmd_ready", {63'd0, icb_cmd_ready}, 64'd0);
        rst_n = 1'b1;
        #1;
        chk("rel_cmd_ready", {63'd0, icb_cmd_ready}, 64'd1);
        step();

        // Upper-lane write, zero wait states
        do_txn(32'h1000_0004, 1'b0, 64'hAAAA_BBBB_CCCC_DDDD, 8'hF0, 0, 32'hDEAD_0000, 1'b0, 0);
        // Lower-lane read, duplicated onto both halves
        do_txn(32'h1000_0000, 1'b1, 64'h0, 8'h00, 0, 32'h1234_5678, 1'b0, 0);
        // Five wait states with slave error
        do_txn(32'h1000_0010, 1'b1, 64'h0, 8'h00, 5, 32'hCAFE_F00D, 1'b1, 0);
        // Response back-pressure
        do_txn(32'h1000_0008, 1'b0, 64'h1111_2222_3333_4444, 8'h0F, 1, 32'h5555_AAAA, 1'b0, 3);

        // Reset while in ACCESS abandons the transfer
        icb_cmd_valid = 1'b1;
        icb_cmd_addr  = 32'h1000_0020;
        icb_cmd_read  = 1'b1;
        step();
        icb_cmd_valid = 1'b0;
        step();
        chk("pre_rst_penable", {63'd0, penable}, 64'd1);
        rst_n = 1'b0;
        step();
        chk("midrst_psel", {63'd0, psel}, 64'd0);
        chk("midrst_penable", {63'd0, penable}, 64'd0);
        chk("midrst_rsp_valid", {63'd0, icb_rsp_valid}, 64'd0);
        chk("midrst_cmd_ready", {63'd0, icb_cmd_ready}, 64'd0);
        rst_n = 1'b1;
        #1;
        chk("postrst_cmd_ready", {63'd0, icb_cmd_ready}, 64'd1);
        step();
        chk("postrst_rsp_valid", {63'd0, icb_rsp_valid}, 64'd0);
        chk("postrst_psel", {63'd0, psel}, 64'd0);

`ifdef ICB_RANGE_CHECK_EN
        do_txn(32'h2000_0000, 1'b1, 64'h0, 8'h00, 0, 32'h9999_9999, 1'b0, 1);
        do_txn(32'h1000_1000, 1'b0, 64'h1, 8'hFF, 0, 32'h0, 1'b0, 0);
`endif

        // Randomized transactions
        for (int n = 0; n < 30; n++) begin
            logic [31:0] ra;
            ra = 32'h1000_0000 + $urandom_range(0, 32'h0FFF);
            do_txn(ra, 1'($urandom), {$urandom, $urandom}, 8'($urandom),
                   $urandom_range(0, 3), $urandom, 1'($urandom), $urandom_range(0, 2));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
